// File: rtl/l1_tag_lru.sv
// l1_tag_lru: tag/valid store and tree pseudo-LRU tracker for a 4-way,
// 32-set L1 cache with 64-byte lines.
//
// A lookup presented on access_i/address_i is captured at a rising edge.
// The result is reported combinationally during the following cycle.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   address_i     lookup address (tag = [31:11], set = [10:6])
//   access_i      lookup request this cycle
//   cache_hit_o   lookup hit, valid the cycle after access_i
//   hit_way_o     lowest matching way, 0 on miss
//   lru_way_o     pseudo-LRU victim way of the latched set
//   update_i      write update_tag_i and set valid at update_set_i/update_way_i
//   invalidate_i  clear valid at update_set_i/update_way_i
//   update_way_i  target way
//   update_tag_i  tag to write
//   update_set_i  target set
//   error_o       sticky self-check failure (update+invalidate, or multi-way hit)
module l1_tag_lru #(
  parameter int NUM_SETS        = 32,
  parameter int SET_INDEX_WIDTH = 5,
  parameter int TAG_WIDTH       = 21
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                address_i,
  input  logic                       access_i,
  output logic                       cache_hit_o,
  output logic [1:0]                 hit_way_o,
  output logic [1:0]                 lru_way_o,
  input  logic                       update_i,
  input  logic                       invalidate_i,
  input  logic [1:0]                 update_way_i,
  input  logic [TAG_WIDTH-1:0]       update_tag_i,
  input  logic [SET_INDEX_WIDTH-1:0] update_set_i,
  output logic                       error_o
);

  localparam int NUM_WAYS = 4;

  // Address fields; the line offset is not used by the tag store.
  logic [SET_INDEX_WIDTH-1:0] addr_set;
  logic [TAG_WIDTH-1:0]       addr_tag;
  logic [5:0]                 addr_offset_unused;

  assign addr_set           = address_i[6 +: SET_INDEX_WIDTH];
  assign addr_tag           = address_i[31 -: TAG_WIDTH];
  assign addr_offset_unused = address_i[5:0];

  // Storage
  logic [TAG_WIDTH-1:0] tag_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [2:0]           plru_q  [NUM_SETS];   // {b2, b1, b0}

  // Lookup pipeline: request plus a snapshot of the set taken at the capture edge.
  logic                       acc_q;
  logic [SET_INDEX_WIDTH-1:0] set_q;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic [NUM_WAYS-1:0]        rd_valid_q;
  logic [TAG_WIDTH-1:0]       rd_tag_q [NUM_WAYS];
  logic                       error_q;

  // NOTE: tag contents are only meaningful behind a valid bit, so the tag
  // array and its read snapshot live in a block without reset; that keeps
  // the array mappable onto plain RAM instead of a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (update_i) begin
      tag_mem[update_set_i][update_way_i] <= update_tag_i;
    end
    // Snapshot taken with non-blocking reads: a same-edge update is not seen.
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_tag_q[w] <= tag_mem[addr_set][w];
    end
  end

  // Lookup compare and victim selection for the latched request.
  logic [NUM_WAYS-1:0] match;
  logic                any_match;
  logic                multi_match;
  logic [1:0]          hit_way;
  logic [2:0]          plru_cur;
  logic [1:0]          victim_way;
  logic [1:0]          touch_way;
  logic [2:0]          plru_next;

  // NOTE: every always_comb output gets a default assignment before any
  // conditional logic, so no path leaves a value held and no latch appears.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = rd_valid_q[w] && (rd_tag_q[w] == tag_q);
    end
    any_match   = |match;
    // More than one bit set: clearing the lowest set bit leaves something.
    multi_match = (match & (match - 4'd1)) != '0;

    hit_way = 2'd0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = 2'(w);
    end

    plru_cur   = plru_q[set_q];
    victim_way = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                             : (plru_cur[1] ? 2'd1 : 2'd0);

    // Touch: root points away from the touched half, the touched pair's bit
    // points at its sibling; the other pair's bit is left alone.
    touch_way    = any_match ? hit_way : victim_way;
    plru_next    = plru_cur;
    plru_next[0] = ~touch_way[1];
    if (!touch_way[1]) plru_next[1] = (touch_way == 2'd0);
    else               plru_next[2] = (touch_way == 2'd2);
  end

  assign cache_hit_o = acc_q && any_match;
  assign hit_way_o   = cache_hit_o ? hit_way : 2'd0;
  assign lru_way_o   = victim_way;
  assign error_o     = error_q;

  // NOTE: all sequential state below uses non-blocking assignments, so every
  // read in this block sees the pre-edge value (this is what makes the
  // lookup snapshot read-before-write with respect to same-edge updates).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      acc_q      <= 1'b0;
      set_q      <= '0;
      tag_q      <= '0;
      rd_valid_q <= '0;
      error_q    <= 1'b0;
    end else begin
      acc_q      <= access_i;
      set_q      <= addr_set;
      tag_q      <= addr_tag;
      rd_valid_q <= valid_q[addr_set];

      // Update has priority over invalidate; asserting both is flagged below.
      if (update_i) begin
        valid_q[update_set_i][update_way_i] <= 1'b1;
      end else if (invalidate_i) begin
        valid_q[update_set_i][update_way_i] <= 1'b0;
      end

      if (acc_q) begin
        plru_q[set_q] <= plru_next;
      end

      if ((update_i && invalidate_i) || (acc_q && multi_match)) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1_tag_lru.sv
// tb_l1_tag_lru: self-checking bench for l1_tag_lru.
// The reference model keeps, per set, a valid/tag table and the pseudo-LRU
// state as "which half is older" plus "older way within each pair".
module tb_l1_tag_lru;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = '0;
  logic        access = 1'b0;
  logic        cache_hit;
  logic [1:0]  hit_way;
  logic [1:0]  lru_way;
  logic        update = 1'b0;
  logic        invalidate = 1'b0;
  logic [1:0]  update_way = '0;
  logic [20:0] update_tag = '0;
  logic [4:0]  update_set = '0;
  logic        error;

  l1_tag_lru dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address_i    (address),
    .access_i     (access),
    .cache_hit_o  (cache_hit),
    .hit_way_o    (hit_way),
    .lru_way_o    (lru_way),
    .update_i     (update),
    .invalidate_i (invalidate),
    .update_way_i (update_way),
    .update_tag_i (update_tag),
    .update_set_i (update_set),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  bit          m_valid [32][4];
  logic [20:0] m_tag   [32][4];
  int          m_old_half [32];  // 0: left pair (ways 0/1) is older, 1: right pair
  int          m_old_left [32];  // older way within pair 0/1
  int          m_old_right[32];  // older way within pair 2/3
  bit          m_err;

  function automatic int m_victim(int s);
    return (m_old_half[s] == 1) ? m_old_right[s] : m_old_left[s];
  endfunction

  function automatic void m_touch(int s, int w);
    if (w < 2) begin
      m_old_half[s] = 1;
      m_old_left[s] = 1 - w;
    end else begin
      m_old_half[s]  = 0;
      m_old_right[s] = 5 - w;
    end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < 32; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_old_half[s]  = 0;
      m_old_left[s]  = 0;
      m_old_right[s] = 2;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] mk_addr(int tag, int set);
    return {21'(tag), 5'(set), 6'(tag * 7 + set)};
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    access = 1'b0; update = 1'b0; invalidate = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One clock cycle: drive inputs at a negedge, model the edge, check the
  // lookup result at the next negedge.
  task automatic do_cycle(input string nm, input bit acc, input logic [31:0] addr,
                          input bit upd, input bit inv, input int way,
                          input int tag, input int set);
    int s, nmatch, ew, exp_way, exp_lru;
    logic [20:0] t;
    bit exp_hit;
    access = acc; address = addr; update = upd; invalidate = inv;
    update_way = 2'(way); update_tag = 21'(tag); update_set = 5'(set);

    s = int'(addr[10:6]);
    t = addr[31:11];
    nmatch = 0; ew = 0;
    for (int w = 3; w >= 0; w--) begin
      if (m_valid[s][w] && m_tag[s][w] == t) begin
        nmatch++;
        ew = w;
      end
    end

    @(posedge clk);
    if (upd) begin
      m_tag[set][way]   = 21'(tag);
      m_valid[set][way] = 1'b1;
    end else if (inv) begin
      m_valid[set][way] = 1'b0;
    end
    if (upd && inv) m_err = 1'b1;

    @(negedge clk);
    access = 1'b0; update = 1'b0; invalidate = 1'b0;
    if (acc) begin
      exp_hit = (nmatch > 0);
      exp_way = exp_hit ? ew : 0;
      exp_lru = m_victim(s);
      n_checks++;
      if (cache_hit !== exp_hit)
        $display("FAIL %s hit: got %0b expected %0b", nm, cache_hit, exp_hit);
      else n_pass++;
      n_checks++;
      if (hit_way !== 2'(exp_way))
        $display("FAIL %s hit_way: got %0d expected %0d", nm, hit_way, exp_way);
      else n_pass++;
      n_checks++;
      if (lru_way !== 2'(exp_lru))
        $display("FAIL %s lru_way: got %0d expected %0d", nm, lru_way, exp_lru);
      else n_pass++;
      m_touch(s, exp_hit ? ew : exp_lru);
    end else begin
      n_checks++;
      if (cache_hit !== 1'b0)
        $display("FAIL %s idle hit: got %0b expected 0", nm, cache_hit);
      else n_pass++;
    end
    n_checks++;
    if (error !== m_err)
      $display("FAIL %s error: got %0b expected %0b", nm, error, m_err);
    else n_pass++;
    if (acc && nmatch > 1) m_err = 1'b1;
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) do_cycle(nm, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_bit(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0b expected %0b", nm, got, exp);
    else n_pass++;
  endtask

  task automatic expect_way(input string nm, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset();
    expect_bit("reset hit", cache_hit, 1'b0);
    expect_way("reset hit_way", hit_way, 2'd0);
    expect_way("reset lru_way", lru_way, 2'd0);
    expect_bit("reset error", error, 1'b0);
  endtask

  task automatic test_first_miss();
    do_cycle("first_miss", 1, 32'h0000_0840, 0, 0, 0, 0, 0);
    expect_bit("first_miss hit", cache_hit, 1'b0);
    expect_way("first_miss lru", lru_way, 2'd0);
    do_cycle("second_miss", 1, 32'h0000_0840, 0, 0, 0, 0, 0);
    expect_way("second_miss lru", lru_way, 2'd2);
  endtask

  task automatic test_update_hit();
    do_cycle("fill_s1w2", 0, '0, 1, 0, 2, 1, 1);
    do_cycle("hit_s1w2", 1, 32'h0000_0840, 0, 0, 0, 0, 0);
    expect_bit("update_hit hit", cache_hit, 1'b1);
    expect_way("update_hit way", hit_way, 2'd2);
  endtask

  task automatic test_read_before_write();
    // Tag 2 in set 1 is address 0x1040; written on the lookup's own edge.
    do_cycle("rbw_same_edge", 1, 32'h0000_1040, 1, 0, 3, 2, 1);
    expect_bit("rbw same-edge hit", cache_hit, 1'b0);
    do_cycle("rbw_next", 1, 32'h0000_1040, 0, 0, 0, 0, 0);
    expect_bit("rbw next hit", cache_hit, 1'b1);
    expect_way("rbw next way", hit_way, 2'd3);
  endtask

  task automatic test_plru_sequence();
    for (int w = 0; w < 4; w++) do_cycle("fill_s5", 0, '0, 1, 0, w, 16 + w, 5);
    do_cycle("plru_hit0", 1, mk_addr(16, 5), 0, 0, 0, 0, 0);
    do_cycle("plru_hit2", 1, mk_addr(18, 5), 0, 0, 0, 0, 0);
    do_cycle("plru_hit1", 1, mk_addr(17, 5), 0, 0, 0, 0, 0);
    expect_way("plru hit1 way", hit_way, 2'd1);
    do_cycle("plru_probe", 1, mk_addr(99, 5), 0, 0, 0, 0, 0);
    expect_way("plru victim after 0,2,1", lru_way, 2'd3);
  endtask

  task automatic test_invalidate_error();
    do_cycle("inv_s1w2", 0, '0, 0, 1, 2, 0, 1);
    do_cycle("inv_lookup", 1, 32'h0000_0840, 0, 0, 0, 0, 0);
    expect_bit("invalidated hit", cache_hit, 1'b0);
    expect_bit("error before conflict", error, 1'b0);
    do_cycle("upd_inv_both", 0, '0, 1, 1, 0, 5, 9);
    expect_bit("error after conflict", error, 1'b1);
    idle("error_hold", 3);
    expect_bit("error held", error, 1'b1);
    apply_reset();
    expect_bit("error cleared by reset", error, 1'b0);
  endtask

  task automatic test_multi_match();
    do_cycle("dup_w0", 0, '0, 1, 0, 0, 7, 7);
    do_cycle("dup_w1", 0, '0, 1, 0, 1, 7, 7);
    do_cycle("dup_lookup", 1, mk_addr(7, 7), 0, 0, 0, 0, 0);
    expect_way("multi hit_way", hit_way, 2'd0);
    idle("multi_after", 1);
    expect_bit("multi error", error, 1'b1);
    apply_reset();
  endtask

  // Random traffic over a few sets and tags so hits, misses, back-to-back
  // same-set lookups and occasional duplicate tags all occur.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int op, tg, st;
      bit acc, upd, inv;
      op  = int'($urandom_range(0, 9));
      acc = ($urandom_range(0, 9) < 7);
      upd = (op < 2);
      inv = (op == 2);
      tg  = int'($urandom_range(0, 3));
      st  = int'($urandom_range(0, 3));
      do_cycle("random", acc, mk_addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
               upd, inv, int'($urandom_range(0, 3)), tg, st);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 8; i++) do_cycle("b2b_miss", 1, mk_addr(40 + i, 12), 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_update_hit();
    test_read_before_write();
    test_plru_sequence();
    test_invalidate_error();
    test_multi_match();
    test_back_to_back();
    apply_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
